// File: rtl/booth_div_seq.sv
// booth_div_seq: sequential signed divider, 2N-bit dividend by N-bit divisor.
// Radix-2 restoring iteration on magnitudes (one quotient bit per clock),
// followed by a sign fix-up: truncation toward zero, remainder takes the
// sign of the dividend.
//
// Optional feature (macro BOOTH_DIV_SATURATE_EN):
//   defined   : on overflow Qo saturates toward the sign of the true quotient
//               (sign of the dividend for divide by zero), R = 0.
//   undefined : on overflow Qo = 0, R = 0. Flags are identical in both builds.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, sampled only in IDLE
//   D      signed 2N-bit dividend, captured on the accepted start edge
//   M      signed N-bit divisor, captured on the accepted start edge
//   Qo     signed N-bit quotient (registered)
//   R      signed N-bit remainder (registered)
//   busy   operation in progress
//   done   one-cycle pulse when Qo/R/ovf/dz are valid
//   ovf    quotient not representable in N bits, or divide by zero
//   dz     divisor was zero
module booth_div_seq #(
   parameter int unsigned N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [2*N-1:0] D,
   input  logic [N-1:0]   M,
   output logic [N-1:0]   Qo,
   output logic [N-1:0]   R,
   output logic           busy,
   output logic           done,
   output logic           ovf,
   output logic           dz
);

   localparam int unsigned DW = 2 * N;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
   // Most negative N-bit value, also the largest negative quotient magnitude.
   localparam logic [N-1:0] Q_LIM = {1'b1, {(N-1){1'b0}}};

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_CALC = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [DW-1:0] dd_q,    dd_d;
   logic [N-1:0]  mm_q,    mm_d;
   logic [N-1:0]  absm_q,  absm_d;
   logic [N-1:0]  prem_q,  prem_d;
   logic [N-1:0]  sreg_q,  sreg_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          sq_q,    sq_d;
   logic          sr_q,    sr_d;
   logic [N-1:0]  qo_q,    qo_d;
   logic [N-1:0]  r_q,     r_d;
   logic          busy_q,  busy_d;
   logic          done_q,  done_d;
   logic          ovf_q,   ovf_d;
   logic          dz_q,    dz_d;

   logic [DW-1:0] absd;
   logic [N-1:0]  absm;
   logic [N:0]    trial;
   logic          trial_ge;
   logic          rng_ovf;
   logic          ovf_all;

   // State register and datapath flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         dd_q    <= '0;
         mm_q    <= '0;
         absm_q  <= '0;
         prem_q  <= '0;
         sreg_q  <= '0;
         cnt_q   <= '0;
         sq_q    <= 1'b0;
         sr_q    <= 1'b0;
         qo_q    <= '0;
         r_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dd_q    <= dd_d;
         mm_q    <= mm_d;
         absm_q  <= absm_d;
         prem_q  <= prem_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         sq_q    <= sq_d;
         sr_q    <= sr_d;
         qo_q    <= qo_d;
         r_q     <= r_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
      end
   end

   // Next-state and datapath logic.
   always_comb begin
      state_d = state_q;
      dd_d    = dd_q;
      mm_d    = mm_q;
      absm_d  = absm_q;
      prem_d  = prem_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      sq_d    = sq_q;
      sr_d    = sr_q;
      qo_d    = qo_q;
      r_d     = r_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      dz_d    = dz_q;
      rng_ovf = 1'b0;
      ovf_all = 1'b0;

      absd     = dd_q[DW-1] ? (~dd_q + DW'(1)) : dd_q;
      absm     = mm_q[N-1]  ? (~mm_q + N'(1))  : mm_q;
      trial    = {prem_q, sreg_q[N-1]};
      trial_ge = (trial >= {1'b0, absm_q});

      case (state_q)
         S_IDLE: begin
            if (start) begin
               dd_d    = D;
               mm_d    = M;
               ovf_d   = 1'b0;
               dz_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = S_LOAD;
            end
         end

         S_LOAD: begin
            sq_d    = dd_q[DW-1] ^ mm_q[N-1];
            sr_d    = dd_q[DW-1];
            absm_d  = absm;
            prem_d  = absd[DW-1:N];
            sreg_d  = absd[N-1:0];
            cnt_d   = CNT_LAST;
            state_d = S_CALC;
            // Fault exits pass through a single idle CALC slot so every
            // early termination has the same fixed latency.
            if (mm_q == '0) begin
               dz_d  = 1'b1;
               ovf_d = 1'b1;
               cnt_d = '0;
            end else if (absd[DW-1:N] >= absm) begin
               ovf_d = 1'b1;
               cnt_d = '0;
            end
         end

         S_CALC: begin
            if (!ovf_q) begin
               prem_d = trial_ge ? N'(trial - {1'b0, absm_q}) : trial[N-1:0];
               sreg_d = {sreg_q[N-2:0], trial_ge};
            end
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         S_FIX: begin
            // Negative quotients may reach one more magnitude than positive.
            rng_ovf = sq_q ? (sreg_q > Q_LIM) : sreg_q[N-1];
            ovf_all = ovf_q | rng_ovf;
            ovf_d   = ovf_all;
            if (ovf_all) begin
`ifdef BOOTH_DIV_SATURATE_EN
               qo_d = (dz_q ? sr_q : sq_q) ? Q_LIM : ~Q_LIM;
`else
               qo_d = '0;
`endif
               r_d  = '0;
            end else begin
               qo_d = sq_q ? (~sreg_q + N'(1)) : sreg_q;
               r_d  = sr_q ? (~prem_q + N'(1)) : prem_q;
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign Qo   = qo_q;
   assign R    = r_q;
   assign busy = busy_q;
   assign done = done_q;
   assign ovf  = ovf_q;
   assign dz   = dz_q;

endmodule

// File: tb/tb_booth_div_seq.sv
// Self-checking bench for booth_div_seq (N = 8). Accepted operations push an
// expected result onto a scoreboard queue; a monitor pops and compares each
// time done pulses. Scenario tasks add their own timing and reset checks.
module tb_booth_div_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] D;
   logic [7:0]  M;
   logic [7:0]  Qo;
   logic [7:0]  R;
   logic        busy;
   logic        done;
   logic        ovf;
   logic        dz;

   typedef struct {
      logic [15:0] d;
      logic [7:0]  m;
      logic [7:0]  qo;
      logic [7:0]  r;
      logic        ovf;
      logic        dz;
      int          lat;
      int          start_cyc;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   booth_div_seq #(.N(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .D     (D),
      .M     (M),
      .Qo    (Qo),
      .R     (R),
      .busy  (busy),
      .done  (done),
      .ovf   (ovf),
      .dz    (dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: integer division truncating toward zero.
   function automatic exp_t model(input logic [15:0] d, input logic [7:0] m);
      exp_t   e;
      longint sd, sm, q, rr, ad, am;
      logic   neg;
      sd = longint'($signed(d));
      sm = longint'($signed(m));
      e.d = d;
      e.m = m;
      e.qo = 8'h00;
      e.r = 8'h00;
      e.dz = 1'b0;
      e.ovf = 1'b0;
      e.start_cyc = 0;
      neg = 1'b0;
      if (sm == 0) begin
         e.dz  = 1'b1;
         e.ovf = 1'b1;
         e.lat = 3;
         neg   = d[15];
      end else begin
         q  = sd / sm;
         rr = sd % sm;
         ad = (sd < 0) ? -sd : sd;
         am = (sm < 0) ? -sm : sm;
         e.lat = (ad >= 256 * am) ? 3 : 10;
         if (q > 127 || q < -128) begin
            e.ovf = 1'b1;
            neg   = d[15] ^ m[7];
         end else begin
            e.qo = 8'(q);
            e.r  = 8'(rr);
         end
      end
      if (e.ovf) begin
`ifdef BOOTH_DIV_SATURATE_EN
         e.qo = neg ? 8'h80 : 8'h7F;
`else
         e.qo = neg ? 8'h00 : 8'h00;
`endif
         e.r = 8'h00;
      end
      return e;
   endfunction

   // Drive one accepted start; DUT must be idle at the next rising edge.
   task automatic issue(input logic [15:0] d, input logic [7:0] m);
      exp_t e;
      @(negedge clk);
      D = d;
      M = m;
      start = 1'b1;
      @(posedge clk);
      #1;
      e = model(d, m);
      e.start_cyc = cyc;
      sb_q.push_back(e);
      start = 1'b0;
      D = 16'($urandom);
      M = 8'($urandom);
   endtask

   task automatic wait_done(input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL done_timeout after %0d cycles (got no done, required done=1)", limit);
      end
   endtask

   task automatic scoreboard_monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done at cycle %0d (got done=1, required 0)", cyc);
            end else begin
               e = sb_q.pop_front();
               checks += 4;
               if (Qo !== e.qo) begin
                  errors++;
                  $display("FAIL qo D=%h M=%h got %h required %h", e.d, e.m, Qo, e.qo);
               end
               if (R !== e.r) begin
                  errors++;
                  $display("FAIL r D=%h M=%h got %h required %h", e.d, e.m, R, e.r);
               end
               if (ovf !== e.ovf || dz !== e.dz) begin
                  errors++;
                  $display("FAIL flags D=%h M=%h got ovf=%b dz=%b required ovf=%b dz=%b",
                           e.d, e.m, ovf, dz, e.ovf, e.dz);
               end
               if (cyc - e.start_cyc !== e.lat) begin
                  errors++;
                  $display("FAIL latency D=%h M=%h got %0d required %0d",
                           e.d, e.m, cyc - e.start_cyc, e.lat);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({Qo, R, busy, done, ovf, dz} !== 20'h0) begin
         errors++;
         $display("FAIL reset_state got Qo=%h R=%h busy=%b done=%b ovf=%b dz=%b required all 0",
                  Qo, R, busy, done, ovf, dz);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int  busy_bad;
      bit  seen;
      busy_bad = 0;
      seen = 1'b0;
      issue(16'd100, 8'd7);
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            if (busy !== 1'b0) busy_bad++;
         end else if (busy !== 1'b1) begin
            busy_bad++;
         end
      end
      checks += 2;
      if (!seen) begin
         errors++;
         $display("FAIL basic_done_timeout (got no done, required done=1)");
      end
      if (busy_bad !== 0) begin
         errors++;
         $display("FAIL busy_window got %0d bad cycles required 0", busy_bad);
      end
   endtask

   task automatic test_signs();
      issue(16'hFF9C, 8'd7);        wait_done(30);
      issue(16'd100, 8'hF9);        wait_done(30);
      issue(16'hFF9C, 8'hF9);       wait_done(30);
      issue(16'd0, 8'h05);          wait_done(30);
      issue(16'hFFFF, 8'h02);       wait_done(30);
   endtask

   task automatic test_overflow();
      issue(16'h8000, 8'h80);       wait_done(30);
      issue(16'd128, 8'hFF);        wait_done(30);
      issue(16'd128, 8'd1);         wait_done(30);
      issue(16'hFF7F, 8'd1);        wait_done(30);
      issue(16'h7FFF, 8'h80);       wait_done(30);
      issue(16'd55, 8'd0);          wait_done(30);
      issue(16'hFFC9, 8'd0);        wait_done(30);
   endtask

   task automatic test_busy_ignore();
      int extra;
      extra = 0;
      issue(16'd100, 8'd7);
      repeat (3) @(negedge clk);
      D = 16'd9;
      M = 8'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(30);
      repeat (15) begin
         @(negedge clk);
         if (done === 1'b1) extra++;
      end
      checks += 2;
      if (extra !== 0) begin
         errors++;
         $display("FAIL ignored_start got %0d extra done pulses required 0", extra);
      end
      if (Qo !== 8'd14 || R !== 8'd2 || busy !== 1'b0) begin
         errors++;
         $display("FAIL result_hold got Qo=%h R=%h busy=%b required Qo=0e R=02 busy=0",
                  Qo, R, busy);
      end
   endtask

   task automatic test_reset_abort();
      int extra;
      extra = 0;
      issue(16'd100, 8'd7);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      sb_q.delete();
      @(negedge clk);
      checks++;
      if ({Qo, R, busy, done, ovf, dz} !== 20'h0) begin
         errors++;
         $display("FAIL abort_state got Qo=%h R=%h busy=%b done=%b ovf=%b dz=%b required all 0",
                  Qo, R, busy, done, ovf, dz);
      end
      rst = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (done === 1'b1) extra++;
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("FAIL abort_no_done got %0d done pulses required 0", extra);
      end
      issue(16'hFF9C, 8'hF9);
      wait_done(30);
   endtask

   task automatic test_back_to_back();
      issue(16'd1000, 8'd33);       wait_done(30);
      issue(16'hC000, 8'd127);      wait_done(30);
      issue(16'h3F80, 8'h81);       wait_done(30);
   endtask

   task automatic test_sweep();
      logic [7:0]  mv;
      logic [15:0] dv;
      int          q;
      issue(16'd128, 8'hFF);        wait_done(30);
      issue(16'h4000, 8'h80);       wait_done(30);
      for (int i = 0; i < 60; i++) begin
         mv = 8'($urandom_range(1, 255));
         q  = int'($urandom_range(0, 255)) - 128;
         dv = 16'(int'($signed(mv)) * q);
         issue(dv, mv);
         wait_done(30);
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      D = '0;
      M = '0;
      fork
         scoreboard_monitor();
      join_none
      test_reset();
      test_basic();
      test_signs();
      test_overflow();
      test_busy_ignore();
      test_reset_abort();
      test_back_to_back();
      test_sweep();
      repeat (3) @(negedge clk);
      checks++;
      if (sb_q.size() !== 0) begin
         errors++;
         $display("FAIL pending_results got %0d outstanding required 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
